// File: rtl/apb_mux_pkg.sv
// apb_mux_pkg: shared state type, response codes and address decode helper
package apb_mux_pkg;
    typedef enum logic [1:0] {IDLE, FWD, ERR} state_t;
    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;
    function automatic logic [31:0] addr_to_idx(input logic [31:0] addr, input logic [31:0] base, input int unsigned bits);
        return (addr - base) >> bits;
    endfunction
endpackage

// File: rtl/apb_watchdog.sv
// apb_watchdog: counts stalled access ticks and flags when the limit is reached
module apb_watchdog #(
    parameter int TimeoutCycles = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic expired
);
    localparam int CW = $clog2(TimeoutCycles);
    logic [CW-1:0] cnt;
    // counter saturates at the limit because tick is gated off once expired
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (tick) cnt <= cnt + 1'b1;
    end
    assign expired = cnt == CW'(TimeoutCycles - 1);
endmodule

// File: rtl/apb_slave_mux.sv
// apb_slave_mux: APB 1-to-N decoder/mux with unmapped-error completion and per-slave timeout fencing
module apb_slave_mux
    import apb_mux_pkg::*;
#(
    parameter int          NumSlaves     = 4,
    parameter int          SlaveAddrBits = 12,
    parameter logic [31:0] BaseAddr      = 32'h4000_0000,
    parameter int          TimeoutCycles = 16
) (
    input  logic                   a_clk,
    input  logic                   a_reset,
    input  logic                   p_clk_en,
    input  logic [31:0]            p_addr,
    input  logic                   p_sel,
    input  logic                   p_enable,
    input  logic                   p_write,
    input  logic [31:0]            p_wdata,
    output logic [31:0]            p_rdata,
    output logic                   p_ready,
    output logic                   p_slverr,
    output logic [NumSlaves-1:0]   s_sel,
    output logic                   s_enable,
    output logic [31:0]            s_addr,
    output logic                   s_write,
    output logic [31:0]            s_wdata,
    input  logic [NumSlaves*32-1:0] s_rdata,
    input  logic [NumSlaves-1:0]   s_ready,
    input  logic [NumSlaves-1:0]   s_slverr,
    output logic [NumSlaves-1:0]   fenced
);
    localparam int IW = NumSlaves > 1 ? $clog2(NumSlaves) : 1;
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [31:0] k;
    logic [NumSlaves-1:0] oh_k, oh_idx;
    logic [31:0] rd [NumSlaves];
    logic hit, setup, acc, expired, rdy, to, err_acc;
    for (genvar i = 0; i < NumSlaves; i++) begin : g_rd
        assign rd[i] = s_rdata[32*i +: 32];
    end
    assign k = addr_to_idx(p_addr, BaseAddr, SlaveAddrBits);
    assign oh_k = NumSlaves'(1) << k;
    assign oh_idx = NumSlaves'(1) << idx;
    assign hit = (p_addr >= BaseAddr) && (k < NumSlaves) && !(|(oh_k & fenced));
    assign setup = p_sel && !p_enable;
    assign acc = p_sel && p_enable;
    assign rdy = s_ready[idx];
    assign to = state == FWD && acc && expired && !rdy;
    assign err_acc = state == ERR && acc;
    apb_watchdog #(.TimeoutCycles(TimeoutCycles)) u_wd (
        .clk(a_clk),
        .rst(a_reset),
        .clr(p_clk_en && state == IDLE),
        .tick(p_clk_en && state == FWD && acc && !rdy && !expired),
        .expired(expired)
    );
    // next state and latched slave index; a slave response beats the timeout
    always_comb begin
        state_n = state;
        idx_n = idx;
        if (p_clk_en) begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        idx_n = k[IW-1:0];
                        state_n = hit ? FWD : ERR;
                    end
                end
                FWD: state_n = (!p_sel || (p_enable && (rdy || expired))) ? IDLE : FWD;
                ERR: state_n = (!p_sel || p_enable) ? IDLE : ERR;
                default: state_n = IDLE;
            endcase
        end
    end
    // state register; the fence is sticky until reset
    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            state <= IDLE;
            idx <= '0;
            fenced <= '0;
        end else if (p_clk_en) begin
            state <= state_n;
            idx <= idx_n;
            if (to) fenced <= fenced | oh_idx;
        end
    end
    // response mux; setup is forwarded to the slave in the same cycle it is decoded
    always_comb begin
        s_sel = state == IDLE ? (oh_k & {NumSlaves{p_sel && hit}}) : state == FWD ? (oh_idx & {NumSlaves{p_sel}}) : '0;
        p_ready = state == FWD ? (rdy || to) : err_acc;
        p_slverr = (to || err_acc) ? RESP_SLVERR : state == FWD ? s_slverr[idx] : RESP_OKAY;
        p_rdata = (state == FWD && !to) ? rd[idx] : '0;
    end
    assign s_enable = p_enable && state == FWD;
    assign s_addr = p_addr;
    assign s_write = p_write;
    assign s_wdata = p_wdata;
endmodule

// File: tb/tb_apb_slave_mux.sv
// tb_apb_slave_mux: directed vector table plus multi-cycle sequences for the APB slave mux
module tb_apb_slave_mux;
    localparam int N = 4;
    logic a_clk = 1'b0;
    logic a_reset, p_clk_en, p_sel, p_enable, p_write;
    logic [31:0] p_addr, p_wdata, p_rdata, s_addr, s_wdata;
    logic p_ready, p_slverr, s_enable, s_write;
    logic [N-1:0] s_sel, s_ready, s_slverr, fenced;
    logic [N*32-1:0] s_rdata;
    int checks = 0;
    int failures = 0;

    apb_slave_mux dut (
        .a_clk(a_clk), .a_reset(a_reset), .p_clk_en(p_clk_en), .p_addr(p_addr),
        .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ready(p_ready), .p_slverr(p_slverr), .s_sel(s_sel),
        .s_enable(s_enable), .s_addr(s_addr), .s_write(s_write), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .s_slverr(s_slverr), .fenced(fenced)
    );

    always #5 a_clk = ~a_clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  rdy;
        logic [3:0]  err;
        logic [3:0]  sel;
        logic        exp_ready;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t v [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic do_setup(input logic [31:0] addr, input logic wr);
        p_sel = 1'b1;
        p_enable = 1'b0;
        p_addr = addr;
        p_write = wr;
        p_wdata = ~addr;
        s_ready = '0;
        s_slverr = '0;
    endtask

    task automatic go_idle();
        p_sel = 1'b0;
        p_enable = 1'b0;
        s_ready = '0;
        s_slverr = '0;
    endtask

    initial begin
        int n;
        int c;
        bit done;
        v[0] = '{32'h4000_1004, 1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 32'hBBBB_0001};
        v[1] = '{32'h4000_0000, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 32'hAAAA_0000};
        v[2] = '{32'h4000_3FFC, 1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b0, 32'hDDDD_0003};
        v[3] = '{32'h4000_4000, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0};
        v[4] = '{32'h3FFF_FFFC, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0};
        v[5] = '{32'hFFFF_FFFC, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0};
        v[6] = '{32'h4000_2008, 1'b0, 4'b0100, 4'b1011, 4'b0100, 1'b1, 1'b0, 32'hCCCC_0002};
        a_reset = 1'b1;
        p_clk_en = 1'b1;
        p_addr = '0;
        p_write = 1'b0;
        p_wdata = '0;
        s_rdata = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        go_idle();
        repeat (2) tick();
        a_reset = 1'b0;
        #3;
        chk("rst_ready", p_ready, 0);
        chk("rst_slverr", p_slverr, 0);
        chk("rst_rdata", p_rdata, 0);
        chk("rst_sel", s_sel, 0);
        chk("rst_fenced", fenced, 0);
        tick();

        for (int i = 0; i < 7; i++) begin
            do_setup(v[i].addr, v[i].wr);
            #3;
            chk($sformatf("v%0d_setup_sel", i), s_sel, v[i].sel);
            chk($sformatf("v%0d_setup_ready", i), p_ready, 0);
            chk($sformatf("v%0d_setup_enable", i), s_enable, 0);
            chk($sformatf("v%0d_addr", i), s_addr, v[i].addr);
            chk($sformatf("v%0d_wdata", i), s_wdata, ~v[i].addr);
            chk($sformatf("v%0d_write", i), s_write, v[i].wr);
            tick();
            p_enable = 1'b1;
            s_ready = v[i].rdy;
            s_slverr = v[i].err;
            #3;
            chk($sformatf("v%0d_acc_sel", i), s_sel, v[i].sel);
            chk($sformatf("v%0d_acc_enable", i), s_enable, |v[i].sel);
            chk($sformatf("v%0d_ready", i), p_ready, v[i].exp_ready);
            chk($sformatf("v%0d_slverr", i), p_slverr, v[i].exp_err);
            chk($sformatf("v%0d_rdata", i), p_rdata, v[i].exp_rdata);
            tick();
        end
        go_idle();
        tick();

        s_rdata[127:96] = 32'hCAFE_F00D;
        do_setup(32'h4000_3010, 1'b0);
        tick();
        for (int j = 1; j <= 4; j++) begin
            p_enable = 1'b1;
            s_ready = (j == 4) ? 4'b1000 : 4'b0000;
            #3;
            chk($sformatf("wait_ready_%0d", j), p_ready, j == 4);
            chk($sformatf("wait_slverr_%0d", j), p_slverr, 0);
            if (j == 4) chk("wait_rdata", p_rdata, 32'hCAFE_F00D);
            tick();
        end
        go_idle();
        tick();

        do_setup(32'h4000_2000, 1'b0);
        tick();
        for (int j = 1; j <= 16; j++) begin
            p_enable = 1'b1;
            #3;
            chk($sformatf("to_ready_%0d", j), p_ready, j == 16);
            chk($sformatf("to_slverr_%0d", j), p_slverr, j == 16);
            if (j == 16) chk("to_rdata", p_rdata, 0);
            tick();
        end
        go_idle();
        #3;
        chk("to_fenced", fenced, 4'b0100);
        tick();
        do_setup(32'h4000_2000, 1'b0);
        #3;
        chk("fenced_setup_sel", s_sel, 0);
        tick();
        p_enable = 1'b1;
        s_ready = 4'b0100;
        #3;
        chk("fenced_acc_sel", s_sel, 0);
        chk("fenced_ready", p_ready, 1);
        chk("fenced_slverr", p_slverr, 1);
        chk("fenced_rdata", p_rdata, 0);
        tick();

        do_setup(32'h4000_1000, 1'b0);
        tick();
        for (int j = 1; j <= 16; j++) begin
            p_enable = 1'b1;
            s_ready = (j == 16) ? 4'b0010 : 4'b0000;
            #3;
            chk($sformatf("race_ready_%0d", j), p_ready, j == 16);
            chk($sformatf("race_slverr_%0d", j), p_slverr, 0);
            tick();
        end
        go_idle();
        #3;
        chk("race_fenced", fenced, 4'b0100);
        tick();

        do_setup(32'h4000_0000, 1'b0);
        tick();
        n = 0;
        c = 0;
        done = 1'b0;
        while (!done && c < 40) begin
            p_enable = 1'b1;
            p_clk_en = (c % 4 == 3);
            s_ready = (p_clk_en && n == 5) ? 4'b0001 : 4'b0000;
            #3;
            if (s_ready[0]) begin
                chk("gate_done_ready", p_ready, 1);
                chk("gate_done_slverr", p_slverr, 0);
                done = 1'b1;
            end else begin
                chk($sformatf("gate_wait_%0d", c), p_ready, 0);
            end
            if (p_clk_en) n++;
            c++;
            tick();
        end
        chk("gate_completed", done, 1);
        p_clk_en = 1'b1;
        go_idle();
        #3;
        chk("gate_fenced", fenced, 4'b0100);
        tick();

        do_setup(32'h4000_3010, 1'b0);
        tick();
        p_enable = 1'b1;
        repeat (2) tick();
        a_reset = 1'b1;
        go_idle();
        tick();
        a_reset = 1'b0;
        #3;
        chk("rst_mid_sel", s_sel, 0);
        chk("rst_mid_ready", p_ready, 0);
        chk("rst_mid_fenced", fenced, 0);
        tick();
        do_setup(32'h4000_2000, 1'b0);
        #3;
        chk("fresh_setup_sel", s_sel, 4'b0100);
        tick();
        p_enable = 1'b1;
        s_ready = 4'b0100;
        #3;
        chk("fresh_ready", p_ready, 1);
        chk("fresh_slverr", p_slverr, 0);
        chk("fresh_rdata", p_rdata, 32'hCCCC_0002);
        tick();
        go_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
